// File: rtl/spi_device_rx_if.sv
// -----------------------------------------------------------------------------
// spi_device_rx_if
//
// Bundles the SPI pins, the receive FIFO read port and the frame status of
// spi_device_rx so the device and its user connect through one port.
//
//   slave  modport : device view (SPI pins and rd_en/overflow_clear in,
//                    FIFO head, occupancy and frame status out)
//   master modport : host/user view (the mirror image)
//
// Signals:
//   spi_sck, spi_mosi, spi_cs_n : asynchronous SPI pins from the host
//   rd_en                       : pop one FIFO entry (ignored when empty)
//   rd_data[8:0]                : FIFO head, bit 8 = first byte of a frame
//   rd_empty, rd_level          : FIFO empty flag and occupancy
//   frame_done                  : one-cycle pulse when CS_N deasserts
//   frame_len, frame_partial    : length / mid-byte-end flag of last frame
//   overflow, overflow_clear    : sticky FIFO-drop flag and its clear
//   dbg_state[1:0]              : {armed, fsm_state} for debug/observation
//
// Optional MISO path, enabled by defining SPI_DEVICE_RX_MISO_EN:
//   spi_miso, tx_data[7:0], tx_next
//
// Handshake: rd_data is valid in every cycle where rd_empty=0; an entry is
// consumed on a rising sys_clk edge where rd_en=1 and rd_empty=0. There is no
// back-pressure toward the SPI host; a byte arriving on a full FIFO is dropped
// and flagged on overflow.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_device_rx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_cs_n;
  logic          rd_en;
  logic [8:0]    rd_data;
  logic          rd_empty;
  logic [LW-1:0] rd_level;
  logic          frame_done;
  logic [15:0]   frame_len;
  logic          frame_partial;
  logic          overflow;
  logic          overflow_clear;
  logic [1:0]    dbg_state;
`ifdef SPI_DEVICE_RX_MISO_EN
  logic          spi_miso;
  logic [7:0]    tx_data;
  logic          tx_next;
`endif

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, rd_en, overflow_clear,
    output rd_data, rd_empty, rd_level, frame_done, frame_len,
           frame_partial, overflow, dbg_state
`ifdef SPI_DEVICE_RX_MISO_EN
    , input tx_data
    , output spi_miso, tx_next
`endif
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, rd_en, overflow_clear,
    input  rd_data, rd_empty, rd_level, frame_done, frame_len,
           frame_partial, overflow, dbg_state
`ifdef SPI_DEVICE_RX_MISO_EN
    , output tx_data
    , input spi_miso, tx_next
`endif
  );

endinterface

// File: rtl/spi_device_rx.sv
// -----------------------------------------------------------------------------
// spi_device_rx
//
// Device-side SPI receiver (mode 0, MSB first). SCK, MOSI and CS_N are
// oversampled in sys_clk through SYNC_STAGES synchroniser flops; SCK gets one
// extra history flop for edge detection. Bytes are deserialised and pushed,
// tagged with a first-of-frame bit, into a first-word-fall-through FIFO.
// Frame completion, length, partial-byte termination and FIFO overflow are
// reported. sys_clk must run at least 8x SCK.
//
// Ports:
//   sys_clk : sole clock
//   rst     : synchronous active-high reset
//   bus     : spi_device_rx_if.slave (SPI pins, FIFO read port, status)
//
// Parameters:
//   SYNC_STAGES : synchroniser depth on the SPI inputs (>= 2)
//   FIFO_DEPTH  : receive FIFO entries (power of two, >= 2)
//
// Build option: define SPI_DEVICE_RX_MISO_EN to add the MISO transmit path
// (spi_miso, tx_data, tx_next on the interface). Without it the block is
// receive-only.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_device_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input logic            sys_clk,
  input logic            rst,
  spi_device_rx_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  // The CS_N chain resets to 0 so that a CS_N held low across reset is never
  // mistaken for a fresh frame start: the receiver only arms after it has seen
  // CS_N high once (see armed_q).
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sck_prev_q;
  logic                   sck_sync;
  logic                   mosi_sync;
  logic                   cs_sync;
  logic                   sck_rise;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      sck_prev_q  <= sck_sync;
    end
  end

  assign sck_sync  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];
  assign cs_sync   = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_sync & ~sck_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM and deserialiser
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        first_q, first_d;
  logic        push_q, push_d;
  logic [7:0]  pend_q, pend_d;
  logic        done_q, done_d;
  logic [15:0] len_q, len_d;
  logic        partial_q, partial_d;

`ifdef SPI_DEVICE_RX_MISO_EN
  logic       sck_fall;
  logic [7:0] tx_q, tx_d;
  logic       tx_next_q, tx_next_d;

  assign sck_fall = ~sck_sync & sck_prev_q;
`endif

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | cs_sync;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    first_d    = first_q;
    push_d     = 1'b0;
    pend_d     = pend_q;
    done_d     = 1'b0;
    len_d      = len_q;
    partial_d  = partial_q;
`ifdef SPI_DEVICE_RX_MISO_EN
    tx_d       = tx_q;
    tx_next_d  = 1'b0;
`endif

    // The pushed entry consumes the first-of-frame tag.
    if (push_q) first_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !cs_sync) begin
          state_d    = ST_ACTIVE;
          shift_d    = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          first_d    = 1'b1;
`ifdef SPI_DEVICE_RX_MISO_EN
          tx_d       = bus.tx_data;
          tx_next_d  = 1'b1;
`endif
        end
      end

      ST_ACTIVE: begin
        if (sck_rise) begin
          shift_d   = {shift_q[6:0], mosi_sync};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Byte complete: the FIFO write happens next cycle from pend_q.
            push_d = 1'b1;
            pend_d = shift_d;
            if (byte_cnt_q != 16'hffff) byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef SPI_DEVICE_RX_MISO_EN
            tx_d      = bus.tx_data;
            tx_next_d = 1'b1;
`endif
          end
        end
`ifdef SPI_DEVICE_RX_MISO_EN
        // The falling edge right after the 8th rising edge must keep the
        // freshly loaded MSB on the line, hence bit_cnt != 0.
        else if (sck_fall && bit_cnt_q != 3'd0) begin
          tx_d = {tx_q[6:0], 1'b0};
        end
`endif
        // Using the _d counters makes an 8th SCK edge seen in the same cycle
        // as CS_N high count as a completed byte.
        if (cs_sync) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          len_d     = byte_cnt_d;
          partial_d = (bit_cnt_d != 3'd0);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      first_q    <= 1'b0;
      push_q     <= 1'b0;
      pend_q     <= '0;
      done_q     <= 1'b0;
      len_q      <= '0;
      partial_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      first_q    <= first_d;
      push_q     <= push_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      len_q      <= len_d;
      partial_q  <= partial_d;
    end
  end

`ifdef SPI_DEVICE_RX_MISO_EN
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tx_q      <= '0;
      tx_next_q <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      tx_next_q <= tx_next_d;
    end
  end

  assign bus.spi_miso = (state_q == ST_ACTIVE) ? tx_q[7] : 1'b0;
  assign bus.tx_next  = tx_next_q;
`endif

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;

  assign pop   = bus.rd_en && (level_q != '0);
  assign full  = (level_q == FULL_LVL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_q && (!full || pop);
  assign drop  = push_q && full && !pop;

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);

    ovf_d = ovf_q;
    if (bus.overflow_clear) ovf_d = 1'b0;
    if (drop)               ovf_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; rd_data is forced to 0 while empty instead.
  always_ff @(posedge sys_clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= {first_q, pend_q};
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_data       = (level_q == '0) ? 9'h000 : mem_q[rd_ptr_q];
  assign bus.rd_empty      = (level_q == '0);
  assign bus.rd_level      = level_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_len     = len_q;
  assign bus.frame_partial = partial_q;
  assign bus.overflow      = ovf_q;
  assign bus.dbg_state     = {armed_q, state_q};

endmodule
